// File: rtl/bits32demux1to2_buf.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : bits32demux1to2_buf                                        |
// | Description : Buffered 32-bit 1-to-2 demultiplexer. One producer stream  |
// |               (valid/ready) is steered by Select into one of two         |
// |               independent circular FIFOs, each draining to its own       |
// |               consumer over a separate valid/ready handshake.            |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
// | Ports                                                                    |
// |   clk        in   1   rising-edge clock                                  |
// |   resetn     in   1   asynchronous active-low reset                      |
// |   Input      in   32  producer data word                                 |
// |   Select     in   1   destination channel of Input (0 / 1)               |
// |   InValid    in   1   producer presents a word                           |
// |   InReady    out  1   word is accepted this cycle                        |
// |   Out0/Out1  out  32  head word of channel 0 / 1                         |
// |   Out0Valid/Out1Valid   out 1  channel FIFO not empty                    |
// |   Out0Ready/Out1Ready   in  1  consumer takes the head word              |
// |   Count0/Count1         out CW occupancy of channel 0 / 1                |
// +--------------------------------------------------------------------------+
module bits32demux1to2_buf #(
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic [31:0]   Input,
  input  logic          Select,
  input  logic          InValid,
  output logic          InReady,
  output logic [31:0]   Out0,
  output logic          Out0Valid,
  input  logic          Out0Ready,
  output logic [31:0]   Out1,
  output logic          Out1Valid,
  input  logic          Out1Ready,
  output logic [CW-1:0] Count0,
  output logic [CW-1:0] Count1
);

  localparam int            AW     = $clog2(DEPTH);
  localparam logic [CW-1:0] C_FULL = CW'(DEPTH);

  logic [1:0]    w_full;
  logic [1:0]    w_push;
  logic [1:0]    w_pop;
  logic [1:0]    w_rdy;
  logic [31:0]   w_head [2];
  logic [CW-1:0] w_cnt  [2];

  assign w_rdy = {Out1Ready, Out0Ready};

  // Acceptance looks only at the selected channel's registered fullness, so a
  // full channel refuses a push even while it is popping (no bypass path).
  assign InReady = Select ? ~w_full[1] : ~w_full[0];

  generate
    for (genvar g = 0; g < 2; g++) begin : g_ch
      localparam logic C_SEL = (g != 0);

      logic [31:0]   mem_q [DEPTH];
      logic [AW-1:0] wr_ptr_q;
      logic [AW-1:0] wr_ptr_d;
      logic [AW-1:0] rd_ptr_q;
      logic [AW-1:0] rd_ptr_d;
      logic [CW-1:0] cnt_q;
      logic [CW-1:0] cnt_d;

      assign w_full[g] = (cnt_q == C_FULL);
      assign w_push[g] = InValid && InReady && (Select == C_SEL);
      assign w_pop[g]  = (cnt_q != '0) && w_rdy[g];

      // Pointers are log2(DEPTH) bits wide, so a plain increment wraps
      // modulo DEPTH.
      always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (w_push[g]) begin
          wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (w_pop[g]) begin
          rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({w_push[g], w_pop[g]})
          2'b10:   cnt_d = cnt_q + CW'(1);
          2'b01:   cnt_d = cnt_q - CW'(1);
          default: cnt_d = cnt_q;
        endcase
      end

      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          wr_ptr_q <= '0;
          rd_ptr_q <= '0;
          cnt_q    <= '0;
          for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
          end
        end else begin
          wr_ptr_q <= wr_ptr_d;
          rd_ptr_q <= rd_ptr_d;
          cnt_q    <= cnt_d;
          if (w_push[g]) begin
            mem_q[wr_ptr_q] <= Input;
          end
        end
      end

      assign w_head[g] = mem_q[rd_ptr_q];
      assign w_cnt[g]  = cnt_q;
    end
  endgenerate

  assign Out0      = w_head[0];
  assign Out1      = w_head[1];
  assign Count0    = w_cnt[0];
  assign Count1    = w_cnt[1];
  assign Out0Valid = (w_cnt[0] != '0);
  assign Out1Valid = (w_cnt[1] != '0);

endmodule
`default_nettype wire

// File: tb/tb_bits32demux1to2_buf.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_bits32demux1to2_buf                                     |
// | Description : Self-checking bench for bits32demux1to2_buf. A reference   |
// |               model of two bounded word queues predicts every output.    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_bits32demux1to2_buf;

  localparam int DEPTH = 2;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          resetn;
  logic [31:0]   Input;
  logic          Select;
  logic          InValid;
  logic          InReady;
  logic [31:0]   Out0;
  logic          Out0Valid;
  logic          Out0Ready;
  logic [31:0]   Out1;
  logic          Out1Valid;
  logic          Out1Ready;
  logic [CW-1:0] Count0;
  logic [CW-1:0] Count1;

  bits32demux1to2_buf #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .Input     (Input),
    .Select    (Select),
    .InValid   (InValid),
    .InReady   (InReady),
    .Out0      (Out0),
    .Out0Valid (Out0Valid),
    .Out0Ready (Out0Ready),
    .Out1      (Out1),
    .Out1Valid (Out1Valid),
    .Out1Ready (Out1Ready),
    .Count0    (Count0),
    .Count1    (Count1)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: one bounded queue of expected words per channel.
  logic [31:0] exp_q0[$];
  logic [31:0] exp_q1[$];
  bit          acc_m;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Consumer ready drivers: 0 = hold rset value, 1 = toggle, else random.
  int   rmode0 = 0;
  int   rmode1 = 0;
  logic rset0  = 1'b0;
  logic rset1  = 1'b0;

  always @(posedge clk) begin
    #2;
    case (rmode0)
      0:       Out0Ready = rset0;
      1:       Out0Ready = ~Out0Ready;
      default: Out0Ready = 1'($urandom);
    endcase
    case (rmode1)
      0:       Out1Ready = rset1;
      1:       Out1Ready = ~Out1Ready;
      default: Out1Ready = 1'($urandom);
    endcase
  end

  // Monitor / scoreboard: compare at the falling edge, then retire the
  // transfers that the coming rising edge will perform.
  always @(negedge clk) begin
    if (!resetn) begin
      exp_q0.delete();
      exp_q1.delete();
      check("rst_valid0", 32'(Out0Valid), 32'd0);
      check("rst_valid1", 32'(Out1Valid), 32'd0);
      check("rst_count0", 32'(Count0), 32'd0);
      check("rst_count1", 32'(Count1), 32'd0);
      check("rst_out0", Out0, 32'h0);
      check("rst_out1", Out1, 32'h0);
      check("rst_inready", 32'(InReady), 32'd1);
    end else begin
      check("inready", 32'(InReady),
            32'(Select ? (exp_q1.size() < DEPTH) : (exp_q0.size() < DEPTH)));
      check("count0", 32'(Count0), 32'(exp_q0.size()));
      check("count1", 32'(Count1), 32'(exp_q1.size()));
      check("valid0", 32'(Out0Valid), 32'(exp_q0.size() != 0));
      check("valid1", 32'(Out1Valid), 32'(exp_q1.size() != 0));
      if (exp_q0.size() != 0) check("out0", Out0, exp_q0[0]);
      if (exp_q1.size() != 0) check("out1", Out1, exp_q1[0]);
      // Acceptance is decided on occupancy before any pop this cycle.
      acc_m = InValid && (Select ? (exp_q1.size() < DEPTH) : (exp_q0.size() < DEPTH));
      if (Out0Ready && exp_q0.size() != 0) void'(exp_q0.pop_front());
      if (Out1Ready && exp_q1.size() != 0) void'(exp_q1.pop_front());
      if (acc_m) begin
        if (Select) exp_q1.push_back(Input);
        else        exp_q0.push_back(Input);
      end
    end
  end

  // Present one word and hold it until the handshake completes.
  // Entered and left at posedge+1.
  task automatic push_word(input logic sel, input logic [31:0] d);
    int k;
    k       = 0;
    InValid = 1'b1;
    Select  = sel;
    Input   = d;
    @(negedge clk);
    while (!InReady && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!InReady) begin
      n_checks++;
      n_errors++;
      $display("FAIL push_timeout: got InReady=0 expected 1 within 50 cycles (sel=%0d)", sel);
    end
    @(posedge clk);
    #1;
    InValid = 1'b0;
  endtask

  task automatic idle(input int n);
    InValid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    resetn    = 1'b0;
    Input     = '0;
    Select    = 1'b0;
    InValid   = 1'b0;
    Out0Ready = 1'b0;
    Out1Ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    resetn = 1'b1;

    // Steering with both consumers ready.
    rset0 = 1'b1; rset1 = 1'b1;
    push_word(1'b0, 32'hAAAA0000);
    push_word(1'b1, 32'h5555FFFF);
    idle(3);

    // Fill channel 0, stall the third word, side-step to channel 1.
    rset0 = 1'b0; rset1 = 1'b0;
    push_word(1'b0, 32'h1);
    push_word(1'b0, 32'h2);
    InValid = 1'b1; Select = 1'b0; Input = 32'h3;
    repeat (2) @(posedge clk);
    #1;
    push_word(1'b1, 32'h77);
    // Full with pop: pop of word 1 happens, push refused, accepted next cycle.
    rset0 = 1'b1;
    push_word(1'b0, 32'h3);
    rset1 = 1'b1;
    idle(4);

    // Wrap/order through channel 1 with a toggling consumer.
    rmode1 = 1;
    for (int i = 1; i <= 8; i++) push_word(1'b1, 32'(i));
    idle(6);

    // Concurrent independence: channel 1 drains its last word while
    // channel 0 takes a push every cycle.
    rmode1 = 0; rset1 = 1'b0;
    push_word(1'b1, 32'hC0FFEE01);
    rset1 = 1'b1; rmode0 = 2;
    for (int i = 0; i < 6; i++) push_word(1'b0, $urandom);
    idle(4);

    // Mid-cycle reset with both channels holding data.
    rmode0 = 0; rset0 = 1'b0; rset1 = 1'b0;
    push_word(1'b0, 32'h11111111);
    push_word(1'b1, 32'h22222222);
    push_word(1'b0, 32'h33333333);
    #2;
    resetn = 1'b0;
    #1;
    check("async_rst_valid0", 32'(Out0Valid), 32'd0);
    check("async_rst_valid1", 32'(Out1Valid), 32'd0);
    check("async_rst_count0", 32'(Count0), 32'd0);
    check("async_rst_count1", 32'(Count1), 32'd0);
    check("async_rst_out0", Out0, 32'h0);
    check("async_rst_out1", Out1, 32'h0);
    check("async_rst_inready", 32'(InReady), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;

    // Randomized traffic, consumers stalling at random.
    rmode0 = 2; rmode1 = 2;
    repeat (600) begin
      InValid = 1'($urandom);
      Select  = 1'($urandom);
      Input   = $urandom;
      @(posedge clk);
      #1;
    end

    // Drain.
    rmode0 = 0; rmode1 = 0; rset0 = 1'b1; rset1 = 1'b1;
    idle(6);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bits32demux1to2_buf.md
# bits32demux1to2_buf

Buffered 32-bit 1-to-2 demultiplexer: the steering counterpart of the datapath's 2-to-1 word mux. It accepts one 32-bit word per cycle from a single producer over a valid/ready handshake. Each word is routed by `Select` into one of two independent FIFOs, and each FIFO drains to its own consumer over a separate valid/ready handshake. It sits wherever one result stream must fan out to two sinks that can stall independently, for example write-back versus forwarding paths.

## Interface
- `DEPTH`, default 2: entries per output FIFO. Must be a power of two, ≥ 2.
- `CW`, default $clog2(DEPTH)+1: width of the occupancy counters. Derived; do not override.

Ports:
- `clk`  input  1  rising-edge clock. The block has one clock.
- `resetn`  input  1  reset, asynchronous and active-low.
- `Input`  input  32  data word from the producer.
- `Select`  input  1  destination of `Input`: 0 routes to channel 0, 1 routes to channel 1. Sampled with `Input`.
- `InValid`  input  1  producer has a word on `Input`/`Select`.
- `InReady`  output  1  block accepts the word this cycle.
- `Out0`  output  32  head word of channel 0.
- `Out0Valid`  output  1  channel 0 FIFO not empty.
- `Out0Ready`  input  1  consumer 0 takes `Out0` this cycle.
- `Out1`  output  32  head word of channel 1.
- `Out1Valid`  output  1  channel 1 FIFO not empty.
- `Out1Ready`  input  1  consumer 1 takes `Out1` this cycle.
- `Count0`  output  CW  occupancy of channel 0 (0..DEPTH).
- `Count1`  output  CW  occupancy of channel 1 (0..DEPTH).

## Operation
- Each channel is a circular FIFO with a write pointer, a read pointer (log2(DEPTH) bits, wrapping modulo DEPTH) and an occupancy counter.
- Channel states:
  - EMPTY: count = 0.
  - PARTIAL: 0 < count < DEPTH.
  - FULL: count = DEPTH.
- `InReady` = (`Select`==0) ? !FULL0 : !FULL1. It is combinational from `Select` and registered counts only. It never depends on `Out0Ready`/`Out1Ready`.
- Push: when `InValid` && `InReady`, the block writes `Input` at the selected channel's write pointer, increments that write pointer, and increments that count. The other channel is untouched.
- Pop on channel N: when `OutNValid` && `OutNReady`, the block increments the read pointer and decrements the count. `OutNReady` while empty has no effect.
- Simultaneous push and pop on the same channel: the count is unchanged and both pointers advance. This is legal in PARTIAL. A FULL channel refuses the push even while it pops in the same cycle (no bypass).
- A push on one channel and a pop on the other in the same cycle proceed independently.
- `OutN` = storage[read pointer N], driven combinationally from registered storage. `OutNValid` = (CountN != 0).
- Words leave each channel in acceptance order. The block imposes no ordering across channels.
- A producer holding `InValid` while `InReady`=0 must keep `Input`/`Select` stable. The block does not require this for correctness; it simply accepts whatever is present when `InReady` rises.

## Timing
- Reset (`resetn`=0, asynchronous): all pointers, counts and storage clear to 0.
  - Outputs during and after reset: `Out0`=`Out1`=32'h0, `Out0Valid`=`Out1Valid`=0, `Count0`=`Count1`=0, `InReady`=1.
  - Release is synchronous to `clk`. The first push can occur on the first rising edge after release.
- Reset asserted mid-transfer discards all buffered words immediately, without waiting for a clock edge.
- Latency: a word accepted at edge k appears on `OutN` with `OutNValid`=1 after edge k. That is one cycle, with no combinational in-to-out path.
- Throughput: one push per cycle into any non-full channel, plus one pop per channel per cycle.
- `Count0`/`Count1` update on the same edge as the push/pop that changes them.
- Pointer wrap: after DEPTH pushes the write pointer returns to 0. Counts saturate logically at DEPTH and cannot overflow, because the push is blocked.

## Test plan
- Reset: drive `resetn`=0 mid-cycle with both channels holding data → `Out0Valid`=`Out1Valid`=0 and `Count0`=`Count1`=0 immediately, `Out0`=`Out1`=0, `InReady`=1.
- Steering: push 32'hAAAA0000 with Select=0, then 32'h5555FFFF with Select=1, both consumers ready → `Out0`=32'hAAAA0000 valid one cycle after the first edge, and `Out1`=32'h5555FFFF one cycle after the second edge. Each valid is a single-cycle pulse.
- Fill/backpressure: with `Out0Ready`=0, push 1, 2, 3 to channel 0 (DEPTH=2) → 1 and 2 accepted, `Count0`=2. `InReady`=0 while Select=0 and the third word holds. With Select=1 during the stall, `InReady`=1 and channel 1 accepts.
- Full with pop: channel 0 FULL, `Out0Ready`=1 and a push to channel 0 in the same cycle → pop of word 1 occurs, push refused, `Count0`=1 after the edge. The next cycle the push of 3 is accepted.
- Wrap/order: stream 32'h1 to 32'h8 into channel 1 with `Out1Ready` toggling every cycle → `Out1` delivers 1..8 in order with no loss or duplication, pointers wrap 4 times, and `Count1` never exceeds 2.
- Concurrent independence: push to channel 0 every cycle while channel 1 pops its last word → `Count1` goes 1→0 and `Out1Valid` falls while `Count0` tracks channel 0's pushes and pops exactly.
